// File: rtl/freespace_update_arbiter.sv
`default_nettype none
// ============================================================================
// freespace_update_arbiter: round-robin arbiter for input-port credit packets
// onto one BFT-bound output link, with a held valid/ack output register.
// Revision: 1.0
// ============================================================================
module freespace_update_arbiter #(
    parameter int PACKET_BITS  = 97,
    parameter int NUM_IN_PORTS = 7,
    parameter int PTR_BITS     = 3
) (
    input  logic                                clk_bft,
    input  logic                                reset_bft,
    input  logic [NUM_IN_PORTS-1:0]             freespace_update,
    input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports,
    output logic [PACKET_BITS-1:0]              stream_out,
    output logic                                stream_out_vld,
    input  logic                                stream_out_ack,
    output logic [PTR_BITS-1:0]                 grant_port,
    output logic [NUM_IN_PORTS-1:0]             pending
);

    localparam int c_SUM_W = PTR_BITS + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]              r_state;
    logic [PTR_BITS-1:0]     r_rr_ptr;
    logic [NUM_IN_PORTS-1:0] r_pending;
    logic [PACKET_BITS-1:0]  r_stream_out;
    logic                    r_vld;
    logic [PTR_BITS-1:0]     r_grant_port;

    logic [PTR_BITS-1:0]     w_ptr_eff;
    logic [PTR_BITS-1:0]     w_winner;
    logic                    w_found;
    logic [c_SUM_W-1:0]      w_idx;
    logic                    w_grant;
    logic [PTR_BITS-1:0]     w_next_ptr;
    logic [NUM_IN_PORTS-1:0] w_clear;
    logic [PACKET_BITS-1:0]  w_slices [NUM_IN_PORTS];
    logic [PACKET_BITS-1:0]  w_sel;

    generate
        for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_slice
            assign w_slices[i] = packet_from_input_ports[PACKET_BITS*i +: PACKET_BITS];
        end
    endgenerate

    // Out-of-range pointer codes fall back to port 0.
    assign w_ptr_eff = ({1'b0, r_rr_ptr} >= c_SUM_W'(NUM_IN_PORTS)) ? '0 : r_rr_ptr;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_IN_PORTS; k++) begin
            w_idx = {1'b0, w_ptr_eff} + c_SUM_W'(k);
            if (w_idx >= c_SUM_W'(NUM_IN_PORTS)) begin
                w_idx = w_idx - c_SUM_W'(NUM_IN_PORTS);
            end
            if (!w_found && r_pending[w_idx[PTR_BITS-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_BITS-1:0];
            end
        end
    end

    assign w_grant    = w_found && ((r_state == IDLE) || stream_out_ack);
    assign w_next_ptr = (w_winner == PTR_BITS'(NUM_IN_PORTS - 1)) ? '0
                                                                 : w_winner + PTR_BITS'(1);
    assign w_clear    = w_grant ? (NUM_IN_PORTS'(1) << w_winner) : '0;
    assign w_sel      = w_slices[w_winner];

    // A pulse arriving in its own grant cycle re-sets the flag: set wins.
    always_ff @(posedge clk_bft or posedge reset_bft) begin
        if (reset_bft) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | freespace_update;
        end
    end

    always_ff @(posedge clk_bft or posedge reset_bft) begin
        if (reset_bft) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_stream_out <= '0;
            r_vld        <= 1'b0;
            r_grant_port <= '0;
        end else begin
            if (w_grant) begin
                r_stream_out <= w_sel;
                r_grant_port <= w_winner;
                r_rr_ptr     <= w_next_ptr;
                r_vld        <= 1'b1;
                r_state      <= SEND;
            end else if ((r_state == SEND) && stream_out_ack) begin
                r_vld   <= 1'b0;
                r_state <= IDLE;
            end
        end
    end

    assign stream_out     = r_stream_out;
    assign stream_out_vld = r_vld;
    assign grant_port     = r_grant_port;
    assign pending        = r_pending;

endmodule
`default_nettype wire
